// File: rtl/sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// sync_fifo_prog
//
// Single-clock FIFO with programmable almost-full / almost-empty thresholds,
// an occupancy count, a synchronous flush, and registered write-ack,
// overflow and underflow pulses.
//
// Optional feature (compile-time macro):
//   SYNC_FIFO_FWFT_EN  defined   -> first-word fall-through. data_out is
//                                   driven combinationally from the head
//                                   entry and is meaningful while empty=0.
//                      undefined -> standard read. data_out is a register
//                                   loaded on each accepted read, giving
//                                   1-cycle read latency.
//
// Parameters:
//   FIFO_WIDTH  data word width in bits (>=1)
//   FIFO_DEPTH  number of entries, power of two, >=2
//   CNT_W       width of the count/threshold buses (derived, do not override)
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset (beats flush, wr_en, rd_en)
//   data_in      write data
//   wr_en        write request
//   rd_en        read request
//   flush        synchronous clear of the contents; data_out holds
//   af_thresh    almost-full threshold (almostfull = count >= af_thresh)
//   ae_thresh    almost-empty threshold (almostempty = count <= ae_thresh)
//   data_out     read data
//   wr_ack       write accepted on the previous edge
//   overflow     write rejected because full on the previous edge
//   underflow    read rejected because empty on the previous edge
//   full         count == FIFO_DEPTH
//   empty        count == 0
//   almostfull   count >= af_thresh
//   almostempty  count <= ae_thresh
//   fifo_count   current occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_WIDTH-1:0] data_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic                  flush,
    input  logic [CNT_W-1:0]      af_thresh,
    input  logic [CNT_W-1:0]      ae_thresh,
    output logic [FIFO_WIDTH-1:0] data_out,
    output logic                  wr_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almostfull,
    output logic                  almostempty,
    output logic [CNT_W-1:0]      fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [PTR_W-1:0] PTR_ZERO  = PTR_W'(0);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    // Storage and state
    logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  wr_ack_r;
    logic                  overflow_r;
    logic                  underflow_r;

    // Next-state and decode signals
    logic [PTR_W-1:0]      wr_ptr_nxt_s;
    logic [PTR_W-1:0]      rd_ptr_nxt_s;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  wr_accept_s;
    logic                  rd_accept_s;
    logic                  mem_we_s;

    // Full/empty come straight from the registered count so the flags can
    // never disagree with fifo_count.
    assign full_s  = (count_r == DEPTH_CNT);
    assign empty_s = (count_r == CNT_ZERO);

    // Acceptance is judged on pre-edge state. On full, a simultaneous read
    // does not make room for the write in the same cycle (no write-through).
    assign wr_accept_s = wr_en && !full_s;
    assign rd_accept_s = rd_en && !empty_s;

    // Flush and reset both suppress the memory write.
    assign mem_we_s = wr_accept_s && !flush && !rst;

    // Next pointer and occupancy values; flush returns everything to zero.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            wr_ptr_nxt_s = PTR_ZERO;
            rd_ptr_nxt_s = PTR_ZERO;
            count_nxt_s  = CNT_ZERO;
        end else begin
            // Power-of-two depth: natural pointer rollover is the modulo wrap.
            if (wr_accept_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (rd_accept_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({wr_accept_s, rd_accept_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    // One-cycle handshake/error pulses; cleared by reset and by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ack_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            wr_ack_r    <= 1'b0;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            wr_ack_r    <= wr_accept_s;
            overflow_r  <= wr_en && full_s;
            underflow_r <= rd_en && empty_s;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is always visible; it is only meaningful while not empty.
    assign data_out = mem_r[rd_ptr_r];
`else
    logic [FIFO_WIDTH-1:0] data_out_r;

    // Registered read port: loads the head on an accepted read, else holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= FIFO_WIDTH'(0);
        end else if (!flush && rd_accept_s) begin
            data_out_r <= mem_r[rd_ptr_r];
        end else begin
            data_out_r <= data_out_r;
        end
    end

    assign data_out = data_out_r;
`endif

    // Status outputs. Unsigned compares make af_thresh=0 force almostfull
    // and ae_thresh>=FIFO_DEPTH force almostempty without special cases.
    assign wr_ack      = wr_ack_r;
    assign overflow    = overflow_r;
    assign underflow   = underflow_r;
    assign full        = full_s;
    assign empty       = empty_s;
    assign almostfull  = (count_r >= af_thresh);
    assign almostempty = (count_r <= ae_thresh);
    assign fifo_count  = count_r;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_prog
//
// Self-checking bench for sync_fifo_prog (FIFO_WIDTH=16, FIFO_DEPTH=8).
// A queue-based reference model tracks contents and the expected registered
// pulses; every output is compared one time unit after each rising edge.
// Directed scenarios are followed by a randomized run with varying
// thresholds, flushes and resets.
// -----------------------------------------------------------------------------
module tb_sync_fifo_prog;

    localparam int W     = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk;
    logic          rst;
    logic [W-1:0]  data_in;
    logic          wr_en;
    logic          rd_en;
    logic          flush;
    logic [CW-1:0] af_thresh;
    logic [CW-1:0] ae_thresh;
    logic [W-1:0]  data_out;
    logic          wr_ack;
    logic          overflow;
    logic          underflow;
    logic          full;
    logic          empty;
    logic          almostfull;
    logic          almostempty;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [W-1:0] model_q [$];
    logic [W-1:0] exp_data;
    logic         exp_ack;
    logic         exp_ovf;
    logic         exp_udf;

    sync_fifo_prog #(
        .FIFO_WIDTH(W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .flush      (flush),
        .af_thresh  (af_thresh),
        .ae_thresh  (ae_thresh),
        .data_out   (data_out),
        .wr_ack     (wr_ack),
        .overflow   (overflow),
        .underflow  (underflow),
        .full       (full),
        .empty      (empty),
        .almostfull (almostfull),
        .almostempty(almostempty),
        .fifo_count (fifo_count)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output against the model after an edge.
    task automatic check_all(input string tag);
        int sz;
        sz = model_q.size();
        check({tag, ":count"}, 32'(fifo_count), 32'(sz));
        check({tag, ":full"},  32'(full),  32'(sz == DEPTH));
        check({tag, ":empty"}, 32'(empty), 32'(sz == 0));
        check({tag, ":afull"}, 32'(almostfull),  32'(sz >= int'(af_thresh)));
        check({tag, ":aempty"}, 32'(almostempty), 32'(sz <= int'(ae_thresh)));
        check({tag, ":wr_ack"}, 32'(wr_ack), 32'(exp_ack));
        check({tag, ":ovf"}, 32'(overflow), 32'(exp_ovf));
        check({tag, ":udf"}, 32'(underflow), 32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
        if (sz != 0) begin
            check({tag, ":dout"}, 32'(data_out), 32'(model_q[0]));
        end
`else
        check({tag, ":dout"}, 32'(data_out), 32'(exp_data));
`endif
    endtask

    // One clock cycle: drive inputs at the falling edge, advance the model
    // using the pre-edge contents, then check just after the rising edge.
    task automatic step(input logic wr, input logic rd, input logic fl,
                        input logic rs, input logic [W-1:0] din, input string tag);
        bit was_full;
        bit was_empty;
        @(negedge clk);
        wr_en   = wr;
        rd_en   = rd;
        flush   = fl;
        rst     = rs;
        data_in = din;
        if (rs) begin
            model_q.delete();
            exp_data = '0;
            exp_ack  = 1'b0;
            exp_ovf  = 1'b0;
            exp_udf  = 1'b0;
        end else if (fl) begin
            model_q.delete();
            exp_ack = 1'b0;
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
        end else begin
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            exp_ack = wr && !was_full;
            exp_ovf = wr && was_full;
            exp_udf = rd && was_empty;
            if (rd && !was_empty) exp_data = model_q.pop_front();
            if (wr && !was_full) model_q.push_back(din);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_wr(input logic [W-1:0] d, input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b0, d, tag);
    endtask

    task automatic do_rd(input string tag);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, tag);
    endtask

    task automatic do_both(input logic [W-1:0] d, input string tag);
        step(1'b1, 1'b1, 1'b0, 1'b0, d, tag);
    endtask

    initial begin
        rst       = 1'b1;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        flush     = 1'b0;
        data_in   = 16'h0000;
        af_thresh = 4'd6;
        ae_thresh = 4'd2;
        exp_data  = 16'h0000;
        exp_ack   = 1'b0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, "reset");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "idle");

        // 1: fill, then overflow
        for (int i = 1; i <= 8; i++) do_wr(16'(i), "fill");
        do_wr(16'hDEAD, "ovf");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "ovf_clear");

        // 2: drain, then underflow (data_out holds last word)
        for (int i = 0; i < 8; i++) do_rd("drain");
        do_rd("udf");
        step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "udf_clear");

        // 3: wrap-around
        for (int i = 0; i < 5; i++) do_wr(16'h0100 + 16'(i), "wrap_w5");
        for (int i = 0; i < 5; i++) do_rd("wrap_r5");
        for (int i = 0; i < 6; i++) do_wr(16'h0A0A + 16'(i) * 16'h0101, "wrap_w6");
        for (int i = 0; i < 6; i++) do_rd("wrap_r6");

        // 4: simultaneous read and write at count 3, empty and full
        for (int i = 0; i < 3; i++) do_wr(16'h0300 + 16'(i), "sim_pre");
        do_both(16'h03AA, "sim_mid");
        for (int i = 0; i < 3; i++) do_rd("sim_drain");
        do_both(16'h03BB, "sim_empty");
        do_rd("sim_drain1");
        for (int i = 0; i < 8; i++) do_wr(16'h0400 + 16'(i), "sim_fill");
        do_both(16'h04FF, "sim_full");
        for (int i = 0; i < 7; i++) do_rd("sim_drain7");

        // 5: flush with a concurrent write
        for (int i = 0; i < 5; i++) do_wr(16'h0500 + 16'(i), "fl_pre");
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0555, "flush");
        do_wr(16'h1234, "fl_wr");
        do_rd("fl_rd");

        // 6: reset wins over a concurrent write and read
        for (int i = 0; i < 4; i++) do_wr(16'h0600 + 16'(i), "rs_pre");
        step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0666, "rst_busy");

        // Randomized run with varying bias and thresholds
        for (int c = 0; c < 3000; c++) begin
            int bias;
            int r;
            logic w;
            logic rd;
            logic fl;
            logic rs;
            bias = (c / 250) % 3;
            if (c % 200 == 0) begin
                af_thresh = 4'($urandom_range(0, 15));
                ae_thresh = 4'($urandom_range(0, 15));
            end
            r  = int'($urandom_range(0, 199));
            rs = (r < 2);
            fl = (r >= 2) && (r < 6);
            w  = ($urandom_range(0, 99) < (bias == 0 ? 75 : (bias == 1 ? 30 : 50)));
            rd = ($urandom_range(0, 99) < (bias == 0 ? 30 : (bias == 1 ? 75 : 50)));
            step(w, rd, fl, rs, 16'($urandom), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.
- Adds programmable almost-full/almost-empty thresholds, an occupancy count output, a synchronous flush, and registered overflow/underflow pulses.
- Optional first-word-fall-through read mode.
- Sits between a producer and a consumer in the same clock domain, typically as a stimulus/response buffer in datapath blocks.

Parameters:
- FIFO_WIDTH, 16, data word width in bits (>=1).
- FIFO_DEPTH, 8, number of entries; power of two, >=2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of count and threshold buses (derived; not to be overridden).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- flush  input  1  synchronous clear of FIFO contents.
- af_thresh  input  CNT_W  almost-full threshold, quasi-static.
- ae_thresh  input  CNT_W  almost-empty threshold, quasi-static.
- data_out  output  FIFO_WIDTH  read data.
- wr_ack  output  1  registered; write accepted on previous edge.
- overflow  output  1  registered; write rejected (full) on previous edge.
- underflow  output  1  registered; read rejected (empty) on previous edge.
- full  output  1  count == FIFO_DEPTH.
- empty  output  1  count == 0.
- almostfull  output  1  count >= af_thresh.
- almostempty  output  1  count <= ae_thresh.
- fifo_count  output  CNT_W  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset (rst=1 at edge): wr_ptr, rd_ptr, count, data_out, wr_ack, overflow, underflow all cleared to 0. Memory contents are not cleared. After reset: empty=1, full=0. rst has priority over flush, wr_en and rd_en.
- Flush (rst=0, flush=1 at edge):
  - Pointers and count cleared to 0; data_out holds its value.
  - wr_ack, overflow and underflow are 0 on the next cycle.
  - wr_en and rd_en are ignored that cycle; no data is written.
- Write acceptance: wr_en && !full, evaluated on pre-edge state. On acceptance: mem[wr_ptr] <= data_in, wr_ptr increments modulo FIFO_DEPTH, wr_ack=1 next cycle. Otherwise wr_ack=0.
- Overflow: wr_en && full -> overflow=1 for exactly one cycle after the edge. The write is dropped and memory is unchanged.
- Read acceptance: rd_en && !empty, evaluated on pre-edge state. On acceptance, rd_ptr increments modulo FIFO_DEPTH.
  - Standard mode: data_out <= mem[rd_ptr], i.e. 1-cycle read latency; data_out holds otherwise.
- Underflow: rd_en && empty -> underflow=1 for one cycle after the edge. rd_ptr and data_out are unchanged.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted; count unchanged.
  - Empty: only the write is accepted, underflow=1, count+1.
  - Full: only the read is accepted, overflow=1, count-1. There is no write-through on full.
- Count and pointers: count updates by +1, -1 or 0 per the accepted operations and never leaves 0..FIFO_DEPTH. Pointers wrap from FIFO_DEPTH-1 to 0.
- Status flags: full, empty, almostfull, almostempty and fifo_count are combinational from the registered count.
  - Threshold compares are unsigned over CNT_W bits.
  - af_thresh=0 forces almostfull=1; ae_thresh >= FIFO_DEPTH forces almostempty=1.
  - Thresholds may change at any time; the flags follow combinationally.

Optional Feature:
SYNC_FIFO_FWFT_EN
- Defined: first-word fall-through.
  - data_out is driven combinationally from mem[rd_ptr] and is valid whenever empty=0.
  - A word written into an empty FIFO appears on data_out in the cycle after the write edge.
  - An accepted read advances rd_ptr, so the next word (or stale memory if the FIFO becomes empty) appears after the edge.
  - data_out is not reset, and its value while empty is unspecified; benches check it only when empty=0.
  - All flag, ack and error behaviour is identical to standard mode.
- Undefined: standard registered read with 1-cycle latency, as described in Behaviour.

Test Plan:
(All scenarios use FIFO_WIDTH=16, FIFO_DEPTH=8, af_thresh=6, ae_thresh=2.)
1. Reset, then write 0x0001..0x0008 over 8 cycles.
   -> wr_ack=1 each following cycle, fifo_count=8, full=1, almostfull=1 from count 6.
   -> 9th write of 0xDEAD gives overflow=1 for one cycle and wr_ack=0; contents are unchanged.
2. From full, read 8 times.
   -> data_out sequence 0x0001..0x0008, each one cycle after its rd_en (standard mode).
   -> empty=1 after the 8th read; almostempty=1 from count 2.
   -> A 9th read gives underflow=1 for one cycle and data_out holds 0x0008.
3. Wrap-around: write 5, read 5, then write 0x0A0A..0x0F0F (6 words) and read 6.
   -> FIFO order is preserved across the pointer wrap; fifo_count returns to 0.
4. Simultaneous operations:
   - At count 3, assert wr_en and rd_en together: count stays 3, wr_ack=1, no errors.
   - At empty, assert both: count becomes 1, underflow=1.
   - At full, assert both: count becomes 7, overflow=1, and the oldest word is read.
5. Flush at count 5 together with wr_en=1:
   -> next cycle count=0, empty=1, wr_ack=0, data_out unchanged.
   -> A subsequent write of 0x1234 followed by a read returns 0x1234.
6. Assert rst with count=4 and wr_en=rd_en=1:
   -> next cycle all outputs reset (data_out=0, empty=1, wr_ack=overflow=underflow=0, fifo_count=0).
